// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and RUN/HALTED(/FAULT) control.
// Optional fetch bounds/alignment checking is enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_stage #(
    parameter int unsigned           A_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0]    RESET_PC = 32'hBFC00000,
    parameter logic [A_WIDTH-1:0]    ROM_TOP  = 32'hBFC00FFC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_en,
    input  logic [A_WIDTH-1:0]   redirect_pc,
    output logic [A_WIDTH-1:0]   imem_addr,
    input  logic [31:0]          imem_data,
    output logic [31:0]          instr_d,
    output logic [A_WIDTH-1:0]   pc_d,
    output logic [A_WIDTH-1:0]   pc_plus4_d,
    output logic                 valid_d,
    output logic                 halted,
    output logic                 fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1
    } state_t;
`endif

    localparam logic [31:0]        EBREAK  = 32'h00100073;
    localparam logic [A_WIDTH-1:0] PC_STEP = A_WIDTH'(32'd4);

    // A fetch is legal only when word aligned and inside the instruction ROM window.
    function automatic logic pc_legal(input logic [A_WIDTH-1:0] pc);
        return (pc[1:0] == 2'b00) && (pc >= RESET_PC) && (pc <= ROM_TOP);
    endfunction

    state_t               state_r, state_s;
    logic [A_WIDTH-1:0]   pc_r, pc_s;
    logic [A_WIDTH-1:0]   pc_plus4_s;
    logic [31:0]          instr_r, instr_s;
    logic [A_WIDTH-1:0]   pc_d_r, pc_d_s;
    logic [A_WIDTH-1:0]   pc_plus4_d_r, pc_plus4_d_s;
    logic                 valid_r, valid_s;
    logic                 halted_r;
    logic                 fetch_ok_s;

    assign pc_plus4_s = pc_r + PC_STEP;

`ifdef FETCH_BOUNDS_CHECK_EN
    logic fault_r;
    assign fetch_ok_s = pc_legal(pc_r);
`else
    assign fetch_ok_s = 1'b1;
`endif

    // Next-state and next IF/ID contents; redirect beats stall beats advance.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        instr_s      = instr_r;
        pc_d_s       = pc_d_r;
        pc_plus4_d_s = pc_plus4_d_r;
        valid_s      = valid_r;
        case (state_r)
            RUN: begin
                if (redirect_en) begin
                    pc_s    = redirect_pc;
                    valid_s = 1'b0;
                end else if (stall) begin
                    valid_s = valid_r;
                end else if (!fetch_ok_s) begin
`ifdef FETCH_BOUNDS_CHECK_EN
                    state_s = FAULT;
`else
                    state_s = RUN;
`endif
                    valid_s = 1'b0;
                end else begin
                    instr_s      = imem_data;
                    pc_d_s       = pc_r;
                    pc_plus4_d_s = pc_plus4_s;
                    valid_s      = 1'b1;
                    // ebreak is delivered downstream but the PC stays on it.
                    if (imem_data == EBREAK) begin
                        state_s = HALTED;
                    end else begin
                        pc_s = pc_plus4_s;
                    end
                end
            end
            HALTED: begin
                valid_s = 1'b0;
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            FAULT: begin
                valid_s = 1'b0;
            end
`endif
            default: begin
                state_s = RUN;
                valid_s = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            pc_r         <= RESET_PC;
            instr_r      <= 32'h00000000;
            pc_d_r       <= '0;
            pc_plus4_d_r <= '0;
            valid_r      <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            instr_r      <= instr_s;
            pc_d_r       <= pc_d_s;
            pc_plus4_d_r <= pc_plus4_d_s;
            valid_r      <= valid_s;
            halted_r     <= (state_s == HALTED);
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    // Fault flag registered alongside the state it reflects.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= (state_s == FAULT);
        end
    end
    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    assign imem_addr  = pc_r;
    assign instr_d    = instr_r;
    assign pc_d       = pc_d_r;
    assign pc_plus4_d = pc_plus4_d_r;
    assign valid_d    = valid_r;
    assign halted     = halted_r;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32, meaning PC and instruction-memory address width.
REQ-002 SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the PC loaded at reset (the instruction ROM base).
REQ-003 SHALL have parameter ROM_TOP, default 32'hBFC00FFC, meaning the highest legal word-aligned fetch address.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1, meaning the clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port stall, input, 1, meaning hold PC and the IF/ID register.
REQ-008 SHALL have port redirect_en, input, 1, meaning a taken branch/jump; load redirect_pc and kill the in-flight fetch.
REQ-009 SHALL have port redirect_pc, input, A_WIDTH, meaning the redirect target.
REQ-010 SHALL have port imem_addr, output, A_WIDTH, meaning the byte address presented to the combinational instruction ROM.
REQ-011 SHALL have port imem_data, input, 32, meaning the assembled instruction word returned combinationally by the ROM.
REQ-012 SHALL have ports instr_d (output, 32), pc_d (output, A_WIDTH) and pc_plus4_d (output, A_WIDTH), meaning the IF/ID register contents.
REQ-013 SHALL have port valid_d, output, 1, meaning the IF/ID register holds a live instruction.
REQ-014 SHALL have ports halted (output, 1) and fault (output, 1), meaning the halt and fetch-fault status flags.

Function
REQ-015 SHALL drive imem_addr directly from the PC register, with no combinational path from redirect_pc to imem_addr.
REQ-016 SHALL implement the states RUN, HALTED and FAULT; halted SHALL be 1 only in HALTED and fault SHALL be 1 only in FAULT.
REQ-017 SHALL, in RUN, apply this priority: redirect_en, then stall, then normal advance.
REQ-018 SHALL, on normal advance, capture {imem_data, PC, PC+4} into {instr_d, pc_d, pc_plus4_d}, set valid_d=1 and set PC to PC+4, so that fetch latency is one cycle from imem_addr to instr_d.
REQ-019 SHALL, on stall without redirect_en, hold PC, instr_d, pc_d, pc_plus4_d and valid_d unchanged.
REQ-020 SHALL, on redirect_en (with or without stall), set PC to redirect_pc and valid_d to 0 on the next edge, giving a one-bubble penalty.
REQ-021 SHALL compute PC+4 modulo 2^A_WIDTH, wrapping silently when the bounds check is compiled out.
REQ-022 SHALL, on normal advance with imem_data equal to 32'h00100073 (ebreak), capture ebreak with valid_d=1, hold PC and enter HALTED.
REQ-023 SHALL, in HALTED, force valid_d to 0 from the next edge, freeze PC, and ignore stall and redirect_en; only rst leaves HALTED.
REQ-024 SHALL treat a redirect_en in the same cycle as an ebreak fetch as a redirect and SHALL NOT enter HALTED.
REQ-025 SHALL NOT interpret imem_data when redirect_en or stall is asserted.

Reset
REQ-026 SHALL, when rst is high at a clock edge, set PC=RESET_PC, state=RUN, valid_d=0, instr_d=0, pc_d=0, pc_plus4_d=0, halted=0 and fault=0, overriding all other inputs.
REQ-027 SHALL, when rst is asserted mid-stall, mid-redirect or in HALTED/FAULT, produce the same state as REQ-026 one edge later.

Configuration
REQ-028 SHALL, when FETCH_BOUNDS_CHECK_EN is defined, enter FAULT if the PC is misaligned (PC[1:0]!=0) or outside RESET_PC..ROM_TOP, instead of capturing imem_data; it SHALL set valid_d=0 and freeze the PC at the faulting value.
REQ-029 SHALL, when FETCH_BOUNDS_CHECK_EN is defined, hold FAULT until rst and ignore all other inputs in FAULT.
REQ-030 SHALL, when FETCH_BOUNDS_CHECK_EN is undefined, tie fault to 0, omit the FAULT state and fetch any PC unchecked.

Verification
REQ-031 SHALL cover reset release with the ROM holding 0x00500093 at 0xBFC00000 -> imem_addr=0xBFC00000, then next cycle instr_d=0x00500093, pc_d=0xBFC00000, pc_plus4_d=0xBFC00004, valid_d=1.
REQ-032 SHALL cover stall held for 3 cycles at PC 0xBFC00008 -> imem_addr and the IF/ID outputs are constant for those 3 cycles, then advance to 0xBFC0000C.
REQ-033 SHALL cover redirect_en with redirect_pc=0xBFC00040 while stall=1 -> next cycle imem_addr=0xBFC00040 and valid_d=0, the cycle after that pc_d=0xBFC00040 and valid_d=1.
REQ-034 SHALL cover ebreak at 0xBFC00010 -> instr_d=0x00100073 with valid_d=1, then halted=1, valid_d=0 and imem_addr=0xBFC00010 frozen despite redirect_en pulses.
REQ-035 SHALL cover, with FETCH_BOUNDS_CHECK_EN defined, redirect_pc=0xBFC01000 -> fault=1, valid_d=0, imem_addr frozen; then rst -> PC=0xBFC00000 and fault=0.
REQ-036 SHALL cover rst asserted in HALTED -> state RUN, halted=0, valid_d=0 and imem_addr=0xBFC00000 one edge later.
